// File: rtl/debug_slave_sysclk_queue.sv
// System-clock receiver for JTAG update-DR/IR strobes; captures {kind, ir, sr} into a DEPTH-entry queue.
// Latency: strobe first sampled high at edge E0 -> entry pushed at E0+SYNC_STAGES -> out_valid after that edge.
// Backpressure: out_valid/out_ready pop; a push into a full queue without a same-cycle pop is dropped and counted.
module debug_slave_sysclk_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SR_WIDTH-1:0]    sr,
  input  logic [IR_WIDTH-1:0]    ir_in,
  input  logic                   vs_udr,
  input  logic                   vs_uir,
  input  logic                   out_ready,
  input  logic                   overrun_clr,
  output logic                   out_valid,
  output logic [SR_WIDTH-1:0]    out_jdo,
  output logic [IR_WIDTH-1:0]    out_ir,
  output logic [1:0]             out_kind,
  output logic [2**IR_WIDTH-1:0] out_ir_onehot,
  output logic                   overrun,
  output logic [7:0]             drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 + IR_WIDTH + SR_WIDTH;

  typedef struct packed {
    logic [1:0]          kind;
    logic [IR_WIDTH-1:0] ir;
    logic [SR_WIDTH-1:0] jdo;
  } entry_t;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_udr_prev;
  logic                   r_uir_prev;
  logic                   r_udr_armed;
  logic                   r_uir_armed;

  entry_t                 r_mem [DEPTH];
  entry_t                 r_hold;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_overrun;
  logic [7:0]             r_drop_cnt;

  logic                   w_udr_s;
  logic                   w_uir_s;
  logic                   w_fill_done;
  logic                   w_udr_ev;
  logic                   w_uir_ev;
  logic                   w_ev;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push_ok;
  logic                   w_drop;
  entry_t                 w_new;
  entry_t                 w_head;
  logic [2**IR_WIDTH-1:0] w_onehot;

  assign w_udr_s     = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_s     = r_uir_sync[SYNC_STAGES-1];
  // The fill chain marks when the synchroniser output reflects a real post-reset sample,
  // so the reset-cleared zeros cannot arm a strobe that was held high through reset.
  assign w_fill_done = r_fill[SYNC_STAGES-1];
  assign w_udr_ev    = w_udr_s & ~r_udr_prev & r_udr_armed;
  assign w_uir_ev    = w_uir_s & ~r_uir_prev & r_uir_armed;
  assign w_ev        = w_udr_ev | w_uir_ev;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = w_valid & out_ready;
  assign w_push_ok = w_ev & (~w_full | w_pop);
  assign w_drop    = w_ev & w_full & ~w_pop;
  assign w_new     = '{kind: {w_uir_ev, w_udr_ev}, ir: ir_in, jdo: sr};

  // Synchronise both strobes, track previous level and arm on the first real low level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_fill      <= '0;
      r_udr_prev  <= 1'b0;
      r_uir_prev  <= 1'b0;
      r_udr_armed <= 1'b0;
      r_uir_armed <= 1'b0;
    end else begin
      r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_udr_prev  <= w_udr_s;
      r_uir_prev  <= w_uir_s;
      r_udr_armed <= r_udr_armed | (w_fill_done & ~w_udr_s);
      r_uir_armed <= r_uir_armed | (w_fill_done & ~w_uir_s);
    end
  end

  // Queue storage is not reset; the count defines which entries are live
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // Pointers, occupancy and the last-popped head copy shown while empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun and saturating drop counter; a same-cycle drop wins over clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overrun  <= 1'b1;
      if (overrun_clr) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (overrun_clr) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head = w_valid ? r_mem[r_rd_ptr] : r_hold;

  // One-hot IR decode of the registered head, only for entries carrying an update-DR
  always_comb begin
    w_onehot = '0;
    if (w_valid && w_head.kind[0]) begin
      w_onehot[w_head.ir] = 1'b1;
    end
  end

  assign out_valid     = w_valid;
  assign out_jdo       = w_head.jdo;
  assign out_ir        = w_head.ir;
  assign out_kind      = w_head.kind;
  assign out_ir_onehot = w_onehot;
  assign overrun       = r_overrun;
  assign drop_cnt      = r_drop_cnt;

  logic [EW-1:0] w_unused_width;
  assign w_unused_width = w_new;

endmodule

// File: tb/tb_debug_slave_sysclk_queue.sv
// Directed bench for debug_slave_sysclk_queue with default parameters.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
// Expected values are hand-computed constants and a small FIFO model.
module tb_debug_slave_sysclk_queue;

  logic        clk;
  logic        reset_n;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr;
  logic        vs_uir;
  logic        out_ready;
  logic        overrun_clr;
  logic        out_valid;
  logic [37:0] out_jdo;
  logic [1:0]  out_ir;
  logic [1:0]  out_kind;
  logic [3:0]  out_ir_onehot;
  logic        overrun;
  logic [7:0]  drop_cnt;

  int n_checks;
  int n_pass;

  logic [37:0] exp_q[$];
  logic [37:0] v;

  debug_slave_sysclk_queue dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sr            (sr),
    .ir_in         (ir_in),
    .vs_udr        (vs_udr),
    .vs_uir        (vs_uir),
    .out_ready     (out_ready),
    .overrun_clr   (overrun_clr),
    .out_valid     (out_valid),
    .out_jdo       (out_jdo),
    .out_ir        (out_ir),
    .out_kind      (out_kind),
    .out_ir_onehot (out_ir_onehot),
    .overrun       (overrun),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One strobe pulse; the third edge is the push edge, where ready/clr may be asserted.
  task automatic pulse(input logic [37:0] d, input logic [1:0] ir, input logic udr, input logic uir,
                       input logic rdy_at_push, input logic clr_at_push);
    sr     = d;
    ir_in  = ir;
    vs_udr = udr;
    vs_uir = uir;
    tick();
    tick();
    vs_udr      = 1'b0;
    vs_uir      = 1'b0;
    out_ready   = rdy_at_push;
    overrun_clr = clr_at_push;
    tick();
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick();
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset_n     = 1'b0;
    sr          = '0;
    ir_in       = '0;
    vs_udr      = 1'b0;
    vs_uir      = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    ticks(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_jdo", out_jdo, 0);
    chk("rst_kind", out_kind, 0);
    chk("rst_onehot", out_ir_onehot, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_drop", drop_cnt, 0);
    reset_n = 1'b1;
    ticks(6);

    // Latency and capture of a single update-DR
    sr     = 38'h2A_1234_5678;
    ir_in  = 2'b10;
    vs_udr = 1'b1;
    tick();
    chk("lat_e0", out_valid, 0);
    tick();
    chk("lat_e1", out_valid, 0);
    tick();
    chk("lat_e2", out_valid, 1);
    tick();
    vs_udr = 1'b0;
    ticks(3);
    chk("t1_jdo", out_jdo, 38'h2A_1234_5678);
    chk("t1_ir", out_ir, 2'b10);
    chk("t1_kind", out_kind, 2'b01);
    chk("t1_onehot", out_ir_onehot, 4'b0100);
    pop();
    chk("t1_empty", out_valid, 0);
    chk("t1_hold", out_jdo, 38'h2A_1234_5678);
    chk("t1_onehot0", out_ir_onehot, 0);

    // Simultaneous DR and IR update -> one combined entry
    pulse(38'h11_0000_0011, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(2);
    chk("t2_valid", out_valid, 1);
    chk("t2_kind", out_kind, 2'b11);
    chk("t2_onehot", out_ir_onehot, 4'b0010);
    pop();
    chk("t2_single", out_valid, 0);

    // IR-only update: no one-hot decode
    pulse(38'h00_0000_0077, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2b_kind", out_kind, 2'b10);
    chk("t2b_onehot", out_ir_onehot, 0);
    pop();

    // Overflow with consumer stalled
    pulse(38'h0A_0000_0001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(38'h0B_0000_0002, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(38'h0C_0000_0003, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_overrun", overrun, 1);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_head0", out_jdo, 38'h0A_0000_0001);
    pop();
    chk("t3_head1", out_jdo, 38'h0B_0000_0002);
    pop();
    chk("t3_empty", out_valid, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("t3_clr_ovr", overrun, 0);
    chk("t3_clr_cnt", drop_cnt, 0);

    // Full queue with pop on the push edge, across pointer wrap
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      v = 38'h100 + 38'(i);
      pulse(v, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(v);
    end
    for (int i = 0; i < 10; i++) begin
      chk("t4_head", out_jdo, exp_q[0]);
      v = 38'h200 + 38'(i);
      pulse(v, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(v);
    end
    chk("t4_no_drop", drop_cnt, 0);
    chk("t4_no_ovr", overrun, 0);
    chk("t4_d0", out_jdo, exp_q[0]);
    pop();
    chk("t4_d1", out_jdo, exp_q[1]);
    chk("t4_v1", out_valid, 1);
    pop();
    chk("t4_count2", out_valid, 0);

    // Strobe held high through reset release
    reset_n = 1'b0;
    vs_udr  = 1'b1;
    ticks(2);
    reset_n = 1'b1;
    ticks(8);
    chk("t5_noev", out_valid, 0);
    vs_udr = 1'b0;
    ticks(4);
    chk("t5_still", out_valid, 0);
    pulse(38'h33_3333_3333, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_one", out_valid, 1);
    chk("t5_jdo", out_jdo, 38'h33_3333_3333);
    pop();
    chk("t5_only", out_valid, 0);

    // Drop counter saturation
    pulse(38'h1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse(38'h2, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      pulse(38'h3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t6_sat", drop_cnt, 255);
    chk("t6_ovr", overrun, 1);
    chk("t6_head", out_jdo, 38'h1);
    pulse(38'h4, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_clrdrop_cnt", drop_cnt, 1);
    chk("t6_clrdrop_ovr", overrun, 1);

    // Async reset with two entries held
    chk("t7_pre", out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t7_valid", out_valid, 0);
    chk("t7_ovr", overrun, 0);
    chk("t7_drop", drop_cnt, 0);
    chk("t7_jdo", out_jdo, 0);
    ticks(2);
    reset_n = 1'b1;
    ticks(2);
    chk("t7_after", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_slave_sysclk_queue.md
Name: debug_slave_sysclk_queue

Overview:
- System-clock-side receiver for the JTAG debug slave. Synchronises the update-DR and update-IR strobes from the TCK domain and captures the shift register and IR on each update.
- Generalises the fixed 38-bit/2-bit single-register capture to parametric SR/IR widths, configurable synchroniser depth, and a DEPTH-entry command queue with valid/ready output.
- Adds overrun detection and a saturating drop counter. Sits between the TCK-domain shift logic and the CPU debug/OCI command decoders.

Parameters:
SR_WIDTH, 38, width of sr and out_jdo
IR_WIDTH, 2, width of ir_in and out_ir
SYNC_STAGES, 2, synchroniser flops per strobe (legal 2..4)
DEPTH, 2, queue entries (power of 2, legal 2..16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_WIDTH  TCK-domain shift register; stable while strobe is high and until the next shift
ir_in  in  IR_WIDTH  TCK-domain instruction register
vs_udr  in  1  update-DR level, asynchronous to clk
vs_uir  in  1  update-IR level, asynchronous to clk
out_ready  in  1  consumer accepts head entry
overrun_clr  in  1  clears overrun and drop_cnt
out_valid  out  1  queue non-empty
out_jdo  out  SR_WIDTH  head entry sr capture
out_ir  out  IR_WIDTH  head entry ir capture
out_kind  out  2  head entry {uir_event, udr_event}
out_ir_onehot  out  2**IR_WIDTH  one-hot decode of out_ir, gated by out_valid & out_kind[0]
overrun  out  1  sticky: an event was dropped
drop_cnt  out  8  saturating count of dropped events

Behaviour:
- Reset (async, reset_n=0):
  - All sync flops, edge registers, arm bits, pointers and count clear.
  - out_valid=0, out_jdo=0, out_ir=0, out_kind=0, out_ir_onehot=0, overrun=0, drop_cnt=0.
- Synchronisers: each strobe passes through a SYNC_STAGES-flop chain. The output feeds a prev register; a rising event is sync_out & ~prev & armed.
- Arming:
  - armed clears on reset.
  - armed sets on the first cycle the synced level is 0.
  - A strobe held high through reset release never produces an event.
- Event:
  - udr_ev and/or uir_ev raise an event.
  - Both in one cycle produce ONE entry with kind=2'b11.
  - Entry = {kind, ir_in, sr}, sampled at the push edge.
- Latency: strobe first sampled high at edge E0 -> entry pushed at edge E0+SYNC_STAGES -> out_valid=1 after that edge.
- Queue:
  - Pop occurs on out_valid & out_ready.
  - Head outputs come from mem[rd_ptr] and are valid only while out_valid=1; after the last pop they hold the last head value.
  - Pointers wrap modulo DEPTH.
  - Count range is 0..DEPTH.
- Full:
  - A push with count==DEPTH and no simultaneous pop is dropped: overrun<=1, drop_cnt<=drop_cnt+1, saturating at 255.
  - Push and pop in the same cycle while full: both accepted, count unchanged.
- Empty: out_ready is ignored; no pointer movement.
- overrun_clr:
  - Clears overrun and drop_cnt next edge.
  - If a drop occurs in the same cycle, the result is overrun=1, drop_cnt=1.
- No combinational path from any input to out_valid or out_kind. out_ir_onehot is combinational from registered head state only.
- Reset mid-operation: queue contents discarded immediately; no partial entry survives.

Test Plan:
- Defaults; sr=38'h2A_1234_5678, ir_in=2'b10, vs_udr pulse 4 clk -> out_valid rises exactly 2 edges after first sample; out_jdo=38'h2A_1234_5678, out_kind=01, out_ir_onehot=4'b0100.
- vs_udr and vs_uir rise same cycle -> single entry, kind=11, count=1.
- out_ready=0, 3 udr pulses, DEPTH=2 -> 2 entries held; 3rd dropped: overrun=1, drop_cnt=1. First pop returns first sr value.
- Full queue, out_ready=1 in the cycle a push arrives -> no drop; count stays 2; order preserved across pointer wrap (10 pushes/pops).
- Hold vs_udr=1 across reset release -> no entry. Drop to 0 then raise -> exactly one entry.
- 300 drops -> drop_cnt=255. overrun_clr coinciding with a drop -> overrun=1, drop_cnt=1. Assert reset_n=0 with 2 entries -> out_valid=0 immediately.
